// File: rtl/gb_lcd_fb_writer_if.sv
// Pixel stream from the LCD side and the framebuffer write bus produced from it.
// master = pixel source / framebuffer RAM side, slave = gb_lcd_fb_writer.
interface gb_lcd_fb_writer_if #(
  parameter int PIX_W  = 2,
  parameter int ADDR_W = 15
);
  logic [PIX_W-1:0]  LD;
  logic              PX_VALID;
  logic              FRAME_START;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_bank;

  modport master (
    output LD, PX_VALID, FRAME_START,
    input  wr_en, wr_addr, wr_data, wr_bank
  );

  modport slave (
    input  LD, PX_VALID, FRAME_START,
    output wr_en, wr_addr, wr_data, wr_bank
  );
endinterface

// File: rtl/gb_lcd_fb_writer.sv
// Captures Game Boy LCD pixels into a double-buffered framebuffer and publishes
// completed frames to a VGA-domain reader, dropping frames the reader has not consumed.
module gb_lcd_fb_writer #(
  parameter int GB_W   = 160,
  parameter int GB_H   = 144,
  parameter int PIX_W  = 2,
  parameter int ADDR_W = 15
) (
  input  logic                GameBoy_clk,
  input  logic                GameBoy_reset,
  gb_lcd_fb_writer_if.slave   fb,
  input  logic                rd_done_tgl,
  output logic                rd_bank,
  output logic [7:0]          frame_count,
  output logic [7:0]          dropped_frames,
  output logic                busy
);

  localparam int X_W = (GB_W > 1) ? $clog2(GB_W) : 1;
  localparam int Y_W = (GB_H > 1) ? $clog2(GB_H) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, PUBLISH} state_t;

  state_t            state_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] lin_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic              pending_q;
  logic [7:0]        frame_count_q;
  logic [7:0]        dropped_q;
  logic [2:0]        sync_q;

  logic ack;
  logic x_last;
  logic y_last;

  // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history.
  assign ack    = sync_q[1] ^ sync_q[2];
  assign x_last = (x_q == X_W'(GB_W - 1));
  assign y_last = (y_q == Y_W'(GB_H - 1));

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      lin_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
      dropped_q     <= '0;
      sync_q        <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], rd_done_tgl};
      wr_en_q <= 1'b0;
      if (ack) pending_q <= 1'b0;

      unique case (state_q)
        IDLE: ;
        CAPTURE: begin
          if (fb.FRAME_START) begin
            if (dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
          end else if (fb.PX_VALID) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= lin_q;
            wr_data_q <= fb.LD;
            lin_q     <= lin_q + ADDR_W'(1);
            if (x_last) begin
              x_q <= '0;
              if (y_last) begin
                y_q     <= '0;
                lin_q   <= '0;
                state_q <= PUBLISH;
              end else begin
                y_q <= y_q + Y_W'(1);
              end
            end else begin
              x_q <= x_q + X_W'(1);
            end
          end
        end
        PUBLISH: begin
          if (!pending_q || ack) begin
            rd_bank_q     <= wr_bank_q;
            wr_bank_q     <= ~wr_bank_q;
            pending_q     <= 1'b1;
            frame_count_q <= frame_count_q + 8'd1;
          end else if (dropped_q != 8'hFF) begin
            dropped_q <= dropped_q + 8'd1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Frame start from any state overrides the per-state counter/write updates above.
      if (fb.FRAME_START) begin
        state_q <= CAPTURE;
        y_q     <= '0;
        if (fb.PX_VALID) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= '0;
          wr_data_q <= fb.LD;
          x_q       <= X_W'(1);
          lin_q     <= ADDR_W'(1);
        end else begin
          x_q   <= '0;
          lin_q <= '0;
        end
      end
    end
  end

  assign fb.wr_en       = wr_en_q;
  assign fb.wr_addr     = wr_addr_q;
  assign fb.wr_data     = wr_data_q;
  assign fb.wr_bank     = wr_bank_q;
  assign rd_bank        = rd_bank_q;
  assign frame_count    = frame_count_q;
  assign dropped_frames = dropped_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_gb_lcd_fb_writer.sv
// Directed bench: a 4x2 instance driven from a vector table plus hand sequences
// for ack timing, and a default-size instance for a full frame and mid-frame reset.
module tb_gb_lcd_fb_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_d, tgl_s, tgl_d;
  logic       rb_s, rb_d, busy_s, busy_d;
  logic [7:0] fc_s, fc_d, df_s, df_d;

  gb_lcd_fb_writer_if #(.PIX_W(2), .ADDR_W(15)) ifs ();
  gb_lcd_fb_writer_if #(.PIX_W(2), .ADDR_W(15)) ifd ();

  gb_lcd_fb_writer #(.GB_W(4), .GB_H(2), .PIX_W(2), .ADDR_W(15)) u_small (
    .GameBoy_clk(clk), .GameBoy_reset(rst_s), .fb(ifs), .rd_done_tgl(tgl_s),
    .rd_bank(rb_s), .frame_count(fc_s), .dropped_frames(df_s), .busy(busy_s)
  );

  gb_lcd_fb_writer #(.GB_W(160), .GB_H(144), .PIX_W(2), .ADDR_W(15)) u_dflt (
    .GameBoy_clk(clk), .GameBoy_reset(rst_d), .fb(ifd), .rd_done_tgl(tgl_d),
    .rd_bank(rb_d), .frame_count(fc_d), .dropped_frames(df_d), .busy(busy_d)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        fs, pv;
    logic [1:0]  ld;
    logic        en;
    logic [14:0] addr;
    logic [1:0]  data;
    logic        wb, rb;
    logic [7:0]  fc, df;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fs, logic pv, logic [1:0] ld, logic en, int addr,
                              logic wb, logic rb, int fc, int df, logic busy);
    vec_t v;
    v.fs = fs; v.pv = pv; v.ld = ld; v.en = en;
    v.addr = 15'(addr); v.data = ld; v.wb = wb; v.rb = rb;
    v.fc = 8'(fc); v.df = 8'(df); v.busy = busy;
    return v;
  endfunction

  task automatic drive_s(input logic fs, input logic pv, input logic [1:0] ld);
    ifs.FRAME_START = fs; ifs.PX_VALID = pv; ifs.LD = ld;
    @(posedge clk); #1;
  endtask

  task automatic drive_d(input logic fs, input logic pv, input logic [1:0] ld);
    ifd.FRAME_START = fs; ifd.PX_VALID = pv; ifd.LD = ld;
    @(posedge clk); #1;
  endtask

  task automatic chk_s(input string tag, input logic wb, input logic rb,
                       input int fc, input int df, input logic busy);
    chk({tag, ".wr_bank"}, 32'(ifs.wr_bank), 32'(wb));
    chk({tag, ".rd_bank"}, 32'(rb_s), 32'(rb));
    chk({tag, ".frame_count"}, 32'(fc_s), 32'(fc));
    chk({tag, ".dropped"}, 32'(df_s), 32'(df));
    chk({tag, ".busy"}, 32'(busy_s), 32'(busy));
  endtask

  // Full 4x2 frame; tgl_at toggles the reader ack alongside that pixel index.
  task automatic frame_s(input int tgl_at);
    drive_s(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == tgl_at) tgl_s = ~tgl_s;
      drive_s(1'b0, 1'b1, 2'(i));
      chk($sformatf("frame.px%0d.addr", i), 32'(ifs.wr_addr), 32'(i));
    end
    drive_s(1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_s = 1'b1; rst_d = 1'b1; tgl_s = 1'b0; tgl_d = 1'b0;
    ifs.FRAME_START = 1'b0; ifs.PX_VALID = 1'b0; ifs.LD = 2'd0;
    ifd.FRAME_START = 1'b0; ifd.PX_VALID = 1'b0; ifd.LD = 2'd0;

    // ---- vector table for the 4x2 instance ----
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 2'(i), 1, i, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    // second frame, reader never acked -> dropped
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 2'(i), 1, i, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    // short frame after 5 pixels, then a complete frame
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 2'(i), 1, i, 1, 0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 2, 1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 2'(i + 2), 1, i, 1, 0, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 3, 0));
    // FRAME_START with PX_VALID from IDLE
    vecs.push_back(mk(1, 1, 3, 1, 0, 1, 0, 1, 3, 1));
    for (int i = 1; i < 8; i++) vecs.push_back(mk(0, 1, 2'(i), 1, i, 1, 0, 1, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 4, 0));

    @(posedge clk); #1;
    chk("rst.wr_en", 32'(ifs.wr_en), 32'd0);
    chk("rst.wr_addr", 32'(ifs.wr_addr), 32'd0);
    chk("rst.wr_data", 32'(ifs.wr_data), 32'd0);
    chk_s("rst", 1'b0, 1'b1, 0, 0, 1'b0);
    rst_s = 1'b0;

    // PX_VALID alone in IDLE must not write
    drive_s(1'b0, 1'b1, 2'd1);
    chk("idle.pv.wr_en", 32'(ifs.wr_en), 32'd0);
    chk("idle.pv.busy", 32'(busy_s), 32'd0);

    foreach (vecs[i]) begin
      drive_s(vecs[i].fs, vecs[i].pv, vecs[i].ld);
      chk($sformatf("v%0d.wr_en", i), 32'(ifs.wr_en), 32'(vecs[i].en));
      if (vecs[i].en) begin
        chk($sformatf("v%0d.wr_addr", i), 32'(ifs.wr_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d.wr_data", i), 32'(ifs.wr_data), 32'(vecs[i].data));
      end
      chk_s($sformatf("v%0d", i), vecs[i].wb, vecs[i].rb, 32'(vecs[i].fc), 32'(vecs[i].df),
            vecs[i].busy);
    end

    // ---- reader acks, then a frame publishes with a swap ----
    tgl_s = ~tgl_s;
    repeat (4) drive_s(1'b0, 1'b0, 2'd0);
    frame_s(-1);
    chk_s("ack.frame3", 1'b0, 1'b1, 2, 4, 1'b0);

    // ack edge lands exactly on the PUBLISH cycle while pending
    frame_s(6);
    chk_s("ack_at_publish", 1'b1, 1'b0, 3, 4, 1'b0);
    // pending must still be set: a frame with no ack is dropped
    frame_s(-1);
    chk_s("pending_kept", 1'b1, 1'b0, 3, 5, 1'b0);

    // ---- default-size instance: full frame with gaps ----
    rst_d = 1'b0;
    drive_d(1'b1, 1'b0, 2'd0);
    chk("dflt.start.busy", 32'(busy_d), 32'd1);
    for (int i = 0; i < 23040; i++) begin
      if (i % 7 == 3) begin
        drive_d(1'b0, 1'b0, 2'd0);
        chk("dflt.gap.wr_en", 32'(ifd.wr_en), 32'd0);
      end
      drive_d(1'b0, 1'b1, 2'(i));
      chk("dflt.wr_en", 32'(ifd.wr_en), 32'd1);
      chk("dflt.wr_addr", 32'(ifd.wr_addr), 32'(i));
      chk("dflt.wr_data", 32'(ifd.wr_data), 32'(i % 4));
    end
    chk("dflt.last.busy", 32'(busy_d), 32'd1);
    drive_d(1'b0, 1'b0, 2'd0);
    chk("dflt.pub.frame_count", 32'(fc_d), 32'd1);
    chk("dflt.pub.wr_bank", 32'(ifd.wr_bank), 32'd1);
    chk("dflt.pub.rd_bank", 32'(rb_d), 32'd0);
    chk("dflt.pub.dropped", 32'(df_d), 32'd0);
    chk("dflt.pub.busy", 32'(busy_d), 32'd0);
    repeat (3) drive_d(1'b0, 1'b1, 2'd0);
    chk("dflt.once.frame_count", 32'(fc_d), 32'd1);
    chk("dflt.once.wr_en", 32'(ifd.wr_en), 32'd0);

    // ---- reset at pixel 100 ----
    drive_d(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 100; i++) drive_d(1'b0, 1'b1, 2'(i + 1));
    chk("dflt.px99.addr", 32'(ifd.wr_addr), 32'd99);
    rst_d = 1'b1;
    #1;
    chk("mid_rst.wr_en", 32'(ifd.wr_en), 32'd0);
    chk("mid_rst.wr_addr", 32'(ifd.wr_addr), 32'd0);
    chk("mid_rst.wr_data", 32'(ifd.wr_data), 32'd0);
    chk("mid_rst.wr_bank", 32'(ifd.wr_bank), 32'd0);
    chk("mid_rst.rd_bank", 32'(rb_d), 32'd1);
    chk("mid_rst.frame_count", 32'(fc_d), 32'd0);
    chk("mid_rst.dropped", 32'(df_d), 32'd0);
    chk("mid_rst.busy", 32'(busy_d), 32'd0);
    @(posedge clk); #1;
    rst_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_d(1'b0, 1'b1, 2'd1);
      chk($sformatf("post_rst%0d.wr_en", i), 32'(ifd.wr_en), 32'd0);
      chk($sformatf("post_rst%0d.busy", i), 32'(busy_d), 32'd0);
    end
    drive_d(1'b1, 1'b1, 2'd2);
    chk("restart.wr_en", 32'(ifd.wr_en), 32'd1);
    chk("restart.wr_addr", 32'(ifd.wr_addr), 32'd0);
    chk("restart.wr_data", 32'(ifd.wr_data), 32'd2);
    chk("restart.busy", 32'(busy_d), 32'd1);
    drive_d(1'b0, 1'b1, 2'd3);
    chk("restart.next.addr", 32'(ifd.wr_addr), 32'd1);
    chk("restart.next.data", 32'(ifd.wr_data), 32'd3);
    drive_d(1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
